// File: rtl/seq101_pkg.sv
// Shared types and defaults for the time-shared "101" detector arbiter.
package seq101_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 5;
    localparam int HIT_W_DEF  = 3;

endpackage

// File: rtl/seq101_core.sv
// Non-overlapping "101" Moore detector; S3 always returns to S0 and drops its input bit.
module seq101_core
    import seq101_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic din,
    output logic detect
);

    logic [1:0] state;
    logic [1:0] state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S0: state_nxt = din ? S1 : S0;
            S1: state_nxt = din ? S1 : S2;
            S2: state_nxt = din ? S3 : S0;
            S3: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S0;
        else if (clr)
            state <= S0;
        else if (en)
            state <= state_nxt;
    end

    assign detect = (state == S3);

endmodule

// File: rtl/seq101_arbiter.sv
// Round-robin arbiter that serialises one requester's word LSB-first into a shared
// seq101_core, stalling while the core reports a detection, and returns a hit count.
module seq101_arbiter
    import seq101_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int HIT_W  = HIT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    input  logic [N_REQ*LEN_W-1:0]    len,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic [HIT_W-1:0]          hits,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   rr, idx, pick;
    logic [DATA_W-1:0]  word;
    logic [LEN_W-1:0]   blen, ptr, sel_len, clamped;
    logic [HIT_W-1:0]   hit_cnt, hit_inc, hits_q;
    logic               core_en, core_clr, consume, detect, last_bit;

    // Scan downward so the candidate nearest rr (searching upward with wrap) wins.
    always_comb begin
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(rr) + k;
            if (j >= N_REQ)
                j = j - N_REQ;
            if (req[j])
                pick = IDX_W'(j);
        end
    end

    assign sel_len  = len[int'(pick)*LEN_W +: LEN_W];
    assign clamped  = (sel_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : sel_len;
    assign last_bit = (ptr == blen - LEN_W'(1));
    assign hit_inc  = (hit_cnt == '1) ? hit_cnt : hit_cnt + HIT_W'(1);

    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        core_clr  = 1'b0;
        consume   = 1'b0;
        unique case (state)
            IDLE: begin
                core_clr = 1'b1;
                if (|req)
                    state_nxt = (clamped == '0) ? DRAIN : SHIFT;
            end
            SHIFT: begin
                // During a stall the core still steps S3->S0; the bit waits.
                core_en = 1'b1;
                if (!detect) begin
                    consume = 1'b1;
                    if (last_bit)
                        state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr      <= '0;
            idx     <= '0;
            word    <= '0;
            blen    <= '0;
            ptr     <= '0;
            hit_cnt <= '0;
            hits_q  <= '0;
        end else begin
            unique case (state)
                IDLE: if (|req) begin
                    idx     <= pick;
                    word    <= data[int'(pick)*DATA_W +: DATA_W];
                    blen    <= clamped;
                    ptr     <= '0;
                    hit_cnt <= '0;
                end
                SHIFT: begin
                    if (detect)
                        hit_cnt <= hit_inc;
                    else if (consume) begin
                        word <= word >> 1;
                        ptr  <= ptr + LEN_W'(1);
                    end
                end
                DRAIN: hits_q <= detect ? hit_inc : hit_cnt;
                DONE:  rr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    seq101_core u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (core_en),
        .clr    (core_clr),
        .din    (word[0]),
        .detect (detect)
    );

    assign grant = (state == SHIFT || state == DRAIN) ? (N_REQ'(1) << idx) : '0;
    assign done  = (state == DONE) ? (N_REQ'(1) << idx) : '0;
    assign hits  = hits_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_seq101_arbiter.sv
// Directed cycle-exact checks of seq101_arbiter with hand-computed expectations.
module tb_seq101_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;
    localparam int HIT_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data;
    logic [N_REQ*LEN_W-1:0]  len;
    logic [N_REQ-1:0]        grant, done;
    logic [HIT_W-1:0]        hits;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    seq101_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .HIT_W(HIT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .data  (data),
        .len   (len),
        .grant (grant),
        .done  (done),
        .hits  (hits),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        data[i*DATA_W +: DATA_W] = d;
        len[i*LEN_W +: LEN_W]    = l;
    endtask

    initial begin
        int          exp_idx [5];
        logic [2:0]  exp_hit [5];
        exp_idx = '{0, 1, 2, 3, 0};
        exp_hit = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1};

        reset = 1'b1;
        req   = '0;
        data  = '0;
        len   = '0;
        tick(2);
        reset = 1'b0;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_hits",  32'(hits),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);

        // bits 1,0,1: S3 reached on last bit, detected in DRAIN
        set_src(0, 16'h0005, 5'd3);
        req = 4'b0001;
        tick(1);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy",  32'(busy),  32'h1);
        req = '0;
        tick(3);
        check("t1_drain_grant", 32'(grant), 32'h1);
        tick(1);
        check("t1_done",  32'(done),  32'h1);
        check("t1_hits",  32'(hits),  32'h1);
        check("t1_done_grant", 32'(grant), 32'h0);
        tick(1);
        check("t1_done_clear", 32'(done), 32'h0);
        check("t1_hits_hold",  32'(hits), 32'h1);
        check("t1_idle_busy",  32'(busy), 32'h0);

        // bits 1,0,1,1,0,1: one stall in cycle 4, done at cycle 9
        set_src(0, 16'h002D, 5'd6);
        req = 4'b0001;
        tick(1);
        check("t2_grant", 32'(grant), 32'h1);
        req = '0;
        tick(7);
        check("t2_c8_done", 32'(done), 32'h0);
        tick(1);
        check("t2_done", 32'(done), 32'h1);
        check("t2_hits", 32'(hits), 32'h2);
        tick(1);

        // len=0 on requester 2
        set_src(2, 16'h0005, 5'd0);
        req = 4'b0100;
        tick(1);
        req = '0;
        check("t3_c1_done", 32'(done), 32'h0);
        tick(1);
        check("t3_done", 32'(done), 32'h4);
        check("t3_hits", 32'(hits), 32'h0);
        tick(1);

        // alternating bits, len=12: three stalls, done at cycle 17
        set_src(1, 16'h1555, 5'd12);
        req = 4'b0010;
        tick(1);
        check("t4_grant", 32'(grant), 32'h2);
        req = '0;
        tick(15);
        check("t4_c16_done", 32'(done), 32'h0);
        tick(1);
        check("t4_done", 32'(done), 32'h2);
        check("t4_hits", 32'(hits), 32'h3);
        tick(1);

        // len=31 clamps to 16, all ones -> no hits, done at cycle 18
        set_src(3, 16'hFFFF, 5'd31);
        req = 4'b1000;
        tick(1);
        check("t5_grant", 32'(grant), 32'h8);
        req = '0;
        tick(16);
        check("t5_c17_done", 32'(done), 32'h0);
        tick(1);
        check("t5_done", 32'(done), 32'h8);
        check("t5_hits", 32'(hits), 32'h0);
        tick(1);

        // round-robin with all requesters held; rr is 0 here
        set_src(0, 16'h0005, 5'd3);
        set_src(1, 16'h0007, 5'd3);
        set_src(2, 16'h0005, 5'd3);
        set_src(3, 16'h0002, 5'd3);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check($sformatf("rr%0d_grant", k), 32'(grant), 32'(1) << exp_idx[k]);
            if (k == 4)
                req = '0;
            tick(4);
            check($sformatf("rr%0d_done", k), 32'(done), 32'(1) << exp_idx[k]);
            check($sformatf("rr%0d_hits", k), 32'(hits), 32'(exp_hit[k]));
            tick(1);
        end

        // reset mid-burst, then rr restarts at 0
        set_src(1, 16'h0005, 5'd8);
        req = 4'b0010;
        tick(1);
        check("t7_grant", 32'(grant), 32'h2);
        req = '0;
        tick(2);
        check("t7_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("t7_rst_grant", 32'(grant), 32'h0);
        check("t7_rst_done",  32'(done),  32'h0);
        check("t7_rst_busy",  32'(busy),  32'h0);
        check("t7_rst_hits",  32'(hits),  32'h0);
        tick(1);
        reset = 1'b0;
        set_src(1, 16'h0007, 5'd3);
        req = 4'b1111;
        tick(1);
        check("t7_regrant", 32'(grant), 32'h1);
        req = '0;
        tick(4);
        check("t7_done", 32'(done), 32'h1);
        check("t7_hits", 32'(hits), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq101_arbiter.md
# seq101_arbiter

Time-shares one non-overlapping "101" Moore sequence detector among N requesters. Each requester presents a parallel word and a bit length. The block arbitrates round-robin and serialises the granted word LSB-first into the detector core. It stalls the bit stream whenever the detector sits in its detect state, so the core drops no bits, and returns a per-burst hit count with a one-cycle done pulse. It sits between requesting datapath units and the shared detector.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, maximum burst length in bits
- LEN_W, 5, width of each length field (holds 0..DATA_W)
- HIT_W, 3, hit-count width (max non-overlapping hits in DATA_W bits is 5)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  N_REQ  per-requester request level
- data  in  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]; bit 0 sent first
- len  in  N_REQ*LEN_W  requester i bit count; values above DATA_W are clamped to DATA_W
- grant  out  N_REQ  one-hot; high for the served requester from the first SHIFT cycle through DRAIN
- done  out  N_REQ  one-hot, one-cycle pulse in the DONE state
- hits  out  HIT_W  detections in the finished burst; valid with done; holds until the next DONE
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Reset values:
  - grant=0, done=0, hits=0, busy=0
  - FSM=IDLE, round-robin pointer rr=0
  - core state=S0
- Core (seq101_core) behaviour:
  - Next-state rules when en=1: S0 -1-> S1, else S0. S1 -0-> S2, else S1. S2 -1-> S3, else S0. S3 -> S0 unconditionally; the input in S3 is discarded.
  - When en=0 the core holds its state.
  - clr (synchronous) forces S0.
  - detect=(state==S3).
- IDLE:
  - If req is nonzero, select the first set bit searching from rr upward with wrap.
  - Latch the winner's index, data and clamped len; clear the core; load bit pointer ptr=0 and hit counter=0.
  - Go to SHIFT, or to DRAIN if len==0.
  - req is sampled only in IDLE.
- SHIFT:
  - If detect=1, stall: en=1, ptr holds, the bit is not consumed, and hits increments.
  - Otherwise present data[ptr] with en=1 and increment ptr.
  - When the bit at ptr==len-1 is consumed, go to DRAIN.
- DRAIN: en=0; if detect=1, hits increments. Then go to DONE.
- DONE:
  - done[idx]=1 and hits is valid; grant=0.
  - rr=(idx+1) mod N_REQ.
  - Go to IDLE.
- Requester obligations: hold data and len stable from request until done.
- Dropping req mid-burst has no effect; the burst completes and done still pulses.
- Hit counter saturates at its maximum; this is unreachable at default parameters.
- Reset asserted mid-burst: immediate return to reset values, with no done pulse.

## Timing
- Cycle 0 is the IDLE cycle that samples req.
- Grant rises at the start of cycle 1.
- done is high in cycle L+S+2, where:
  - L = clamped len
  - S = number of stall cycles, i.e. hits whose S3 occurs before the last bit is consumed
- len=0: DRAIN in cycle 1, DONE in cycle 2, hits=0.
- Minimum request-to-request spacing: the same requester can be regranted at the earliest in the IDLE cycle following DONE (cycle L+S+3 samples req).
- Simultaneous requests are resolved only by the rr order; there is no priority input.
- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.

## Structure
- Package seq101_pkg holds:
  - FSM state enum: IDLE, SHIFT, DRAIN, DONE
  - core state constants S0..S3 (2-bit)
  - default DATA_W, LEN_W, HIT_W
- Sub-module seq101_core: the Moore detector with en and clr inputs and detect output.
- The arbiter FSM, rr pointer, bit pointer and hit counter live in seq101_arbiter.

## Test plan
- Single requester, one hit: req=0001, data[0]=6'b000101, len=3 → grant=0001 in cycle 1; detect in DRAIN; done=0001 in cycle 5 with hits=1.
- Stall path: data[0]=6'b101101, len=6 → one stall cycle in cycle 4; done in cycle 9 with hits=2; all 6 bits consumed.
- Round-robin: req=1111 held, each with len=3 → grants in order 0001, 0010, 0100, 1000, 0001; each done 5 cycles after its IDLE sample.
- Edge lengths:
  - len=0 → done in cycle 2, hits=0.
  - len=31 with data=16'hFFFF → clamped to 16 bits; done in cycle 18, hits=0.
- Non-overlap: data=16'b0001_0101_0101_0101 (bits LSB-first 1,0,1,0,1,0,1,0,1,0,1,0…), len=12 → expected count computed with stalls applied; the bench model must match cycle-exact.
- Reset mid-burst: assert reset in cycle 3 of a len=8 burst → grant, done, busy and hits all 0 immediately; the next request is served from rr=0 with correct hits.
